lsu_sram_ctrl: RTL and testbench

Load/store controller sitting directly upstream of the single-port data SRAM (1-cycle registered read, word-wide, no byte enables). It accepts byte/half/word load and store requests from the CPU memory stage over a valid/ready interface. It performs read-modify-write for sub-word stores and extracts/extends sub-word loads. Results return over a valid/ready response channel.

---
 rtl/lsu_sram_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_sram_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sram_ctrl
// Purpose  : Byte/half/word load-store controller for a 1-cycle single-port
//            SRAM; sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_sram_ctrl #(
    parameter int N_WIDTH = 32,
    parameter int N_ADDR  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [N_ADDR+1:0]   req_addr,
    input  logic [N_WIDTH-1:0]  req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N_WIDTH-1:0]  rsp_rdata,
    output logic                rsp_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [N_ADDR-1:0]   mem_addr,
    output logic [N_WIDTH-1:0]  mem_din,
    input  logic [N_WIDTH-1:0]  mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAPT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic [1:0]           r_off;
    logic [15:0]          r_wdata;
    logic [N_ADDR-1:0]    r_addr;
    logic [N_WIDTH-1:0]   r_din;
    logic [N_WIDTH-1:0]   r_rdata;
    logic                 r_err;

    logic                 w_err;
    logic                 w_word_st;
    logic [4:0]           w_shamt;
    logic [N_WIDTH-1:0]   w_lane;
    logic [N_WIDTH-1:0]   w_load;
    logic [N_WIDTH-1:0]   w_mask;
    logic [N_WIDTH-1:0]   w_ins;
    logic [N_WIDTH-1:0]   w_merge;

    assign w_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_word_st = req_we && (req_size == 2'b10);

    // Half accesses are aligned, so the byte-offset shift also covers 16*addr[1].
    assign w_shamt = {r_off, 3'b000};
    assign w_lane  = mem_dout >> w_shamt;
    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_ins   = {16'h0000, r_wdata} << w_shamt;
    assign w_merge = (mem_dout & ~w_mask) | (w_ins & w_mask);

    always_comb begin
        w_load = mem_dout;
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_load = mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)          w_next = S_RESP;
                    else if (w_word_st) w_next = S_WR;
                    else                w_next = S_RD;
                end
            end
            S_RD:    w_next = S_CAPT;
            S_CAPT:  w_next = r_we ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= 16'h0000;
            r_addr   <= '0;
            r_din    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        r_addr   <= req_addr[N_ADDR+1:2];
                        r_rdata  <= '0;
                        r_err    <= w_err;
                        if (!w_err && w_word_st) begin
                            r_din <= req_wdata;
                        end
                    end
                end
                S_CAPT: begin
                    if (r_we) r_din   <= w_merge;
                    else      r_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mem_en    = (r_state == S_RD) || (r_state == S_WR);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = r_addr;
    assign mem_din   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_lsu_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_sram_ctrl
// Purpose  : Randomized self-checking bench for lsu_sram_ctrl with an SRAM
//            model and a word-array reference of memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_sram_ctrl;

    localparam int c_AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [c_AW+1:0]   req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [c_AW-1:0]   mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    logic [31:0]       sram    [0:(1<<c_AW)-1];
    logic [31:0]       ref_mem [0:(1<<c_AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_sram_ctrl #(.N_WIDTH(32), .N_ADDR(c_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input int hold);
        int          w;
        int          off;
        logic        bad;
        int          lat, n_en, n_we, n, c_en, c_we;
        logic [31:0] v, mask, held;
        w   = int'(addr[11:2]);
        off = int'(addr[1:0]);
        bad = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) || (size == 2'd2 && off != 0);
        v   = 32'h0;
        if (bad) begin
            lat = 1; n_en = 0; n_we = 0;
        end else if (we) begin
            if (size == 2'd2) begin
                lat = 2; n_en = 1; n_we = 1;
            end else begin
                lat = 4; n_en = 2; n_we = 1;
            end
        end else begin
            lat = 3; n_en = 1; n_we = 0;
            v = ref_mem[w] >> (8 * off);
            if (size == 2'd0) begin
                v = v & 32'hFF;
                if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                v = v & 32'hFFFF;
                if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
        end

        @(posedge clk); #1;
        check("req_ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        n = 1; c_en = int'(mem_en); c_we = int'(mem_we);
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++; c_en += int'(mem_en); c_we += int'(mem_we);
        end
        check("latency", n, lat);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, bad});
        check("rsp_rdata", rsp_rdata, v);
        check("mem_en_cycles", c_en, n_en);
        check("mem_we_cycles", c_we, n_we);

        held = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_we = $urandom; req_size = $urandom;
            req_addr = $urandom; req_wdata = $urandom;
            @(posedge clk); #1;
            check("hold_valid", {31'b0, rsp_valid}, 32'h1);
            check("hold_rdata", rsp_rdata, held);
            check("hold_ready", {31'b0, req_ready}, 32'h0);
            check("hold_mem_en", {31'b0, mem_en}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hs_valid", {31'b0, rsp_valid}, 32'h0);
        check("post_hs_ready", {31'b0, req_ready}, 32'h1);

        if (!bad && we) begin
            if (size == 2'd2) begin
                ref_mem[w] = wdata;
            end else begin
                mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                ref_mem[w] = (ref_mem[w] & ~mask) | ((wdata << (8 * off)) & mask);
            end
        end
    endtask

    task automatic reset_mid_op();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 12'h024; req_wdata = 32'h0000_0055; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rst_mem_en2", {31'b0, mem_en}, 32'h0);
        check("rst_mem_word", sram[9], ref_mem[9]);
    endtask

    initial begin
        for (int i = 0; i < (1 << c_AW); i++) begin
            sram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_dout = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_en", {30'b0, mem_en, mem_we}, 32'h0);
        check("rst_addr", {22'b0, mem_addr}, 32'h0);
        check("rst_din", mem_din, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'b0, rsp_err}, 32'h0);

        do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 0);
        do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h1122_3344, 0);
        do_req(1'b1, 2'd0, 1'b1, 12'h022, 32'hFFFF_FFAA, 0);
        do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 0);
        check("rmw_word", ref_mem[8], 32'h11AA_3344);
        do_req(1'b1, 2'd2, 1'b0, 12'h030, 32'h8001_F0FF, 0);
        do_req(1'b0, 2'd0, 1'b1, 12'h030, 32'h0, 0);
        do_req(1'b0, 2'd0, 1'b0, 12'h030, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b1, 12'h032, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 12'h032, 32'h0, 0);
        do_req(1'b0, 2'd1, 1'b0, 12'h041, 32'h0, 0);
        do_req(1'b1, 2'd2, 1'b0, 12'h042, 32'h1234_5678, 0);
        do_req(1'b1, 2'd3, 1'b0, 12'h040, 32'h1234_5678, 0);
        do_req(1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 5);
        reset_mid_op();

        for (int t = 0; t < 300; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   12'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 16; i++) begin
            check("mem_final", sram[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
